// File: rtl/shadow_chain_collector_pkg.sv
// shadow_chain_collector_pkg: shared tag, defaults and FSM state type for the shadow chain collector
package shadow_pkg;
  localparam logic [7:0] TRAILER_TAG = 8'hA5;
  localparam int DEF_WORD_W = 32;
  localparam int DEF_CNT_W = 16;
  typedef enum logic [2:0] {IDLE, DUMP, PAD, NEXT, TRAIL, DRAIN} collector_state_t;
endpackage

// File: rtl/shadow_chain_collector_if.sv
// shadow_chain_collector_if: chain capture and word readout signals between collector and debug host
interface shadow_chain_collector_if import shadow_pkg::*; #(parameter int CHAINS = 4, parameter int WORD_W = DEF_WORD_W);
  logic dump_req;
  logic [CHAINS-1:0] chains_out;
  logic [CHAINS-1:0] chains_out_vld;
  logic [CHAINS-1:0] chains_out_done;
  logic [CHAINS-1:0] dump_en;
  logic [WORD_W-1:0] word_out;
  logic word_vld;
  logic word_rdy;
  logic busy;
  logic overflow;
  modport master(output dump_req, chains_out, chains_out_vld, chains_out_done, word_rdy,
                 input dump_en, word_out, word_vld, busy, overflow);
  modport slave(input dump_req, chains_out, chains_out_vld, chains_out_done, word_rdy,
                output dump_en, word_out, word_vld, busy, overflow);
endinterface

// File: rtl/shadow_chain_collector_fifo.sv
// shadow_word_fifo: synchronous word FIFO with extra-MSB pointer wrap, full FIFO accepts push only alongside pop
module shadow_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic we, re;
  assign empty = wptr == rptr;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign we = push && (!full || pop);
  assign re = pop && !empty;
  assign dout = mem[rptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= we ? wptr + 1'b1 : wptr;
      rptr <= re ? rptr + 1'b1 : rptr;
    end
  end
  always_ff @(posedge clk)
    if (we) mem[wptr[AW-1:0]] <= din;
endmodule

// File: rtl/shadow_chain_collector.sv
// shadow_chain_collector: drains serial shadow chains one at a time into trailer-closed readout words
module shadow_chain_collector import shadow_pkg::*; #(
  parameter int CHAINS = 4,
  parameter int WORD_W = DEF_WORD_W,
  parameter int DEPTH = 16,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic sh_clk,
  input logic sh_rst,
  shadow_chain_collector_if.slave bus
);
  localparam int IW = CHAINS > 1 ? $clog2(CHAINS) : 1;
  localparam int FW = $clog2(WORD_W);
  collector_state_t state;
  logic [IW-1:0] idx;
  logic [FW-1:0] fill, fill_nxt;
  logic [WORD_W-1:0] sreg, nxt, din, trailer, dout;
  logic [CNT_W-1:0] bit_cnt;
  logic [CHAINS-1:0] sel_out, sel_vld, sel_done;
  logic bit_ok, done_sel, wrap, push, pop, full, empty, ovf;
  always_comb begin
    sel_out = bus.chains_out >> idx;
    sel_vld = bus.chains_out_vld >> idx;
    sel_done = bus.chains_out_done >> idx;
    bit_ok = state == DUMP && sel_vld[0];
    done_sel = state == DUMP && sel_done[0];
    wrap = fill == FW'(WORD_W - 1);
    nxt = sreg | (WORD_W'(sel_out[0]) << fill);
    fill_nxt = bit_ok ? (wrap ? '0 : fill + 1'b1) : fill;
    trailer = (WORD_W'(TRAILER_TAG) << (WORD_W - 8)) | (WORD_W'(CHAINS) << CNT_W) | WORD_W'(bit_cnt);
    push = (bit_ok && wrap) || state == PAD || state == TRAIL;
    din = state == TRAIL ? trailer : state == PAD ? sreg : nxt;
    pop = !empty && bus.word_rdy;
  end
  shadow_word_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clk(sh_clk), .rst(sh_rst), .push(push), .din(din), .full(full),
    .pop(pop), .dout(dout), .empty(empty)
  );
  assign bus.dump_en = state == DUMP ? CHAINS'(1) << idx : '0;
  assign bus.word_out = dout;
  assign bus.word_vld = !empty;
  assign bus.busy = state != IDLE;
  assign bus.overflow = ovf;
  always_ff @(posedge sh_clk) begin
    if (sh_rst) begin
      state <= IDLE;
      idx <= '0;
      fill <= '0;
      sreg <= '0;
      bit_cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (push && full && !pop) ovf <= 1'b1;
      case (state)
        IDLE: if (bus.dump_req) begin
          state <= DUMP;
          idx <= '0;
          fill <= '0;
          sreg <= '0;
          bit_cnt <= '0;
        end
        DUMP: begin
          if (bit_ok) begin
            bit_cnt <= bit_cnt + 1'b1;
            sreg <= wrap ? '0 : nxt;
          end
          fill <= fill_nxt;
          if (done_sel) state <= fill_nxt != '0 ? PAD : NEXT;
        end
        PAD: begin
          fill <= '0;
          sreg <= '0;
          state <= NEXT;
        end
        NEXT: begin
          idx <= idx == IW'(CHAINS - 1) ? idx : idx + 1'b1;
          state <= idx == IW'(CHAINS - 1) ? TRAIL : DUMP;
        end
        TRAIL: state <= DRAIN;
        DRAIN: state <= empty ? IDLE : DRAIN;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shadow_chain_collector.sv
// tb_shadow_chain_collector: directed-vector bench for the shadow chain collector
module tb_shadow_chain_collector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n = 0;
  int err = 0;
  always #5 clk = ~clk;
  shadow_chain_collector_if #(.CHAINS(1), .WORD_W(32)) ia();
  shadow_chain_collector_if #(.CHAINS(2), .WORD_W(32)) ib();
  shadow_chain_collector_if #(.CHAINS(1), .WORD_W(32)) ic();
  shadow_chain_collector #(.CHAINS(1), .WORD_W(32), .DEPTH(16), .CNT_W(16)) dut_a(.sh_clk(clk), .sh_rst(rst), .bus(ia));
  shadow_chain_collector #(.CHAINS(2), .WORD_W(32), .DEPTH(16), .CNT_W(16)) dut_b(.sh_clk(clk), .sh_rst(rst), .bus(ib));
  shadow_chain_collector #(.CHAINS(1), .WORD_W(32), .DEPTH(2), .CNT_W(16)) dut_c(.sh_clk(clk), .sh_rst(rst), .bus(ic));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic a_bit(input logic v, input logic b, input logic d);
    ia.chains_out_vld = v;
    ia.chains_out = b;
    ia.chains_out_done = d;
    @(negedge clk);
  endtask
  task automatic b_bit(input logic [1:0] v, input logic [1:0] b, input logic [1:0] d);
    ib.chains_out_vld = v;
    ib.chains_out = b;
    ib.chains_out_done = d;
    @(negedge clk);
  endtask
  task automatic c_bit(input logic v, input logic b, input logic d);
    ic.chains_out_vld = v;
    ic.chains_out = b;
    ic.chains_out_done = d;
    @(negedge clk);
  endtask
  task automatic rd_a(input string tag, input logic [31:0] exp);
    for (int t = 0; t < 20 && !ia.word_vld; t++) @(negedge clk);
    check(tag, ia.word_vld ? ia.word_out : 32'hDEAD_0000, exp);
    ia.word_rdy = 1'b1;
    @(negedge clk);
    ia.word_rdy = 1'b0;
  endtask
  task automatic rd_b(input string tag, input logic [31:0] exp);
    for (int t = 0; t < 20 && !ib.word_vld; t++) @(negedge clk);
    check(tag, ib.word_vld ? ib.word_out : 32'hDEAD_0000, exp);
    ib.word_rdy = 1'b1;
    @(negedge clk);
    ib.word_rdy = 1'b0;
  endtask
  task automatic rd_c(input string tag, input logic [31:0] exp);
    for (int t = 0; t < 20 && !ic.word_vld; t++) @(negedge clk);
    check(tag, ic.word_vld ? ic.word_out : 32'hDEAD_0000, exp);
    ic.word_rdy = 1'b1;
    @(negedge clk);
    ic.word_rdy = 1'b0;
  endtask
  task automatic idle_wait();
    for (int t = 0; t < 10 && (ia.busy || ib.busy || ic.busy); t++) @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
  initial begin
    {ia.dump_req, ia.chains_out, ia.chains_out_vld, ia.chains_out_done, ia.word_rdy} = '0;
    {ib.dump_req, ib.chains_out, ib.chains_out_vld, ib.chains_out_done, ib.word_rdy} = '0;
    {ic.dump_req, ic.chains_out, ic.chains_out_vld, ic.chains_out_done, ic.word_rdy} = '0;
    repeat (3) @(negedge clk);
    check("rst_en", 32'(ib.dump_en), 0);
    check("rst_vld", 32'(ia.word_vld), 0);
    check("rst_busy", 32'(ia.busy), 0);
    check("rst_ovf", 32'(ia.overflow), 0);
    rst = 1'b0;
    @(negedge clk);
    ia.dump_req = 1'b1;
    @(negedge clk);
    ia.dump_req = 1'b0;
    check("t1_en", 32'(ia.dump_en), 1);
    check("t1_busy", 32'(ia.busy), 1);
    for (int i = 0; i < 15; i++) a_bit(1'b1, 1'b1, i == 14);
    a_bit(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("t1_hold0", ia.word_out, 32'h0000_7FFF);
    @(negedge clk);
    check("t1_hold1", ia.word_out, 32'h0000_7FFF);
    rd_a("t1_w0", 32'h0000_7FFF);
    rd_a("t1_trl", 32'hA501_000F);
    idle_wait();
    check("t1_idle", 32'(ia.busy), 0);
    check("t1_empty", 32'(ia.word_vld), 0);
    ib.dump_req = 1'b1;
    @(negedge clk);
    ib.dump_req = 1'b0;
    check("t2_en0", 32'(ib.dump_en), 1);
    for (int i = 0; i < 32; i++) b_bit(2'b11, {1'b1, i % 2 == 0}, {1'b0, i == 31});
    check("t2_en1", 32'(ib.dump_en), 0);
    b_bit(2'b00, 2'b00, 2'b00);
    check("t2_en2", 32'(ib.dump_en), 2);
    b_bit(2'b10, 2'b10, 2'b00);
    b_bit(2'b10, 2'b10, 2'b00);
    b_bit(2'b10, 2'b00, 2'b10);
    check("t2_en3", 32'(ib.dump_en), 0);
    b_bit(2'b00, 2'b00, 2'b00);
    rd_b("t2_w0", 32'h5555_5555);
    rd_b("t2_w1", 32'h0000_0003);
    rd_b("t2_trl", 32'hA502_0023);
    check("t2_ovf", 32'(ib.overflow), 0);
    idle_wait();
    check("t2_idle", 32'(ib.busy), 0);
    ia.dump_req = 1'b1;
    @(negedge clk);
    ia.dump_req = 1'b0;
    a_bit(1'b0, 1'b0, 1'b1);
    a_bit(1'b0, 1'b0, 1'b0);
    rd_a("t3_trl", 32'hA501_0000);
    idle_wait();
    check("t3_idle", 32'(ia.busy), 0);
    ic.dump_req = 1'b1;
    @(negedge clk);
    ic.dump_req = 1'b0;
    for (int i = 0; i < 33; i++) c_bit(1'b1, i < 16 || i == 32, i == 32);
    c_bit(1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("t4_ovf", 32'(ic.overflow), 1);
    rd_c("t4_w0", 32'h0000_FFFF);
    rd_c("t4_w1", 32'h0000_0001);
    check("t4_only2", 32'(ic.word_vld), 0);
    idle_wait();
    check("t4_idle", 32'(ic.busy), 0);
    ic.dump_req = 1'b1;
    @(negedge clk);
    ic.dump_req = 1'b0;
    check("t4_sticky", 32'(ic.overflow), 1);
    c_bit(1'b0, 1'b0, 1'b1);
    c_bit(1'b0, 1'b0, 1'b0);
    rd_c("t4_trl", 32'hA501_0000);
    idle_wait();
    ib.dump_req = 1'b1;
    @(negedge clk);
    ib.dump_req = 1'b0;
    b_bit(2'b01, 2'b01, 2'b00);
    b_bit(2'b01, 2'b01, 2'b00);
    b_bit(2'b01, 2'b01, 2'b00);
    rst = 1'b1;
    @(negedge clk);
    check("t5_en", 32'(ib.dump_en), 0);
    check("t5_vld", 32'(ib.word_vld), 0);
    check("t5_busy", 32'(ib.busy), 0);
    rst = 1'b0;
    b_bit(2'b00, 2'b00, 2'b00);
    ib.dump_req = 1'b1;
    @(negedge clk);
    ib.dump_req = 1'b0;
    b_bit(2'b01, 2'b01, 2'b00);
    b_bit(2'b01, 2'b00, 2'b00);
    b_bit(2'b01, 2'b01, 2'b00);
    b_bit(2'b01, 2'b01, 2'b00);
    b_bit(2'b01, 2'b00, 2'b01);
    b_bit(2'b00, 2'b00, 2'b10);
    rd_b("t5_w0", 32'h0000_000D);
    rd_b("t5_trl", 32'hA502_0005);
    b_bit(2'b00, 2'b00, 2'b00);
    idle_wait();
    check("t5_idle", 32'(ib.busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n, err);
    $finish;
  end
endmodule
